// File: rtl/hpdmc_rdcapture.sv
// Read-data capture: merges DDR halves into 32-bit words and buffers each burst in a FIFO.
// Command-to-rd_valid latency rd_delay+2; rd_ready low stalls the FIFO, a full FIFO drops captures.

// Generic synchronous FIFO with registered storage; head visible the cycle after its push.
// Full FIFO accepts a push only when the head is popped in the same cycle.
module hpdmc_rdcapture_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  always_comb begin
    rd_vld = (cnt_q != '0);
    wr_rdy = (cnt_q != (AW+1)'(DEPTH)) || rd_rdy;
    rd_dat = rd_vld ? mem_q[rptr_q] : '0;
    push   = wr_vld & wr_rdy;
    pop    = rd_vld & rd_rdy;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wptr_q] = wr_dat;
    end
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// Capture stage: delay line picks burst start, counter tags the last word, FIFO feeds the bus.
// Capture is one word per cycle; output stalls on rd_ready, overflow flags dropped words.
module hpdmc_rdcapture #(
  parameter int BURST_LEN    = 4,
  parameter int RD_DELAY_MAX = 7,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rd_start,
  input  logic [2:0]  rd_delay,
  input  logic        word_swap,
  input  logic [15:0] iddr_q0,
  input  logic [15:0] iddr_q1,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        busy,
  output logic        overflow,
  output logic        overlap_err,
  input  logic        clear_err
);
  localparam int CW = $clog2(BURST_LEN);

  typedef struct packed {
    logic        last;
    logic [31:0] dat;
  } rd_word_t;

  logic [RD_DELAY_MAX:0] dly_q, dly_d;
  logic                  act_q, act_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  ovl_q, ovl_d;
  logic                  tap, start, cap_vld, cap_rdy, fifo_vld;
  rd_word_t              cap_dat, head_dat;

  always_comb begin
    dly_d = {dly_q[RD_DELAY_MAX-1:0], rd_start};
    // dly_q[k] holds a rd_start sampled k+1 edges ago
    tap   = dly_q[rd_delay];
    start = tap & ~act_q;
    cap_vld = start | act_q;
    cap_dat.last = act_q && (cnt_q == CW'(1));
    cap_dat.dat  = word_swap ? {iddr_q1, iddr_q0} : {iddr_q0, iddr_q1};
    act_d = act_q;
    cnt_d = cnt_q;
    if (start) begin
      act_d = 1'b1;
      cnt_d = CW'(BURST_LEN - 1);
    end else if (act_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        act_d = 1'b0;
      end
    end
    ovf_d = (ovf_q & ~clear_err) | (cap_vld & ~cap_rdy);
    ovl_d = (ovl_q & ~clear_err) | (tap & act_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dly_q <= '0;
      act_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      ovl_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      ovl_q <= ovl_d;
    end
  end

  hpdmc_rdcapture_fifo #(
    .W     ($bits(rd_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_vld (cap_vld),
    .wr_dat (cap_dat),
    .wr_rdy (cap_rdy),
    .rd_vld (fifo_vld),
    .rd_dat (head_dat),
    .rd_rdy (rd_ready)
  );

  assign rd_valid    = fifo_vld;
  assign rd_data     = head_dat.dat;
  assign rd_last     = head_dat.last;
  assign busy        = (|dly_q) | act_q | fifo_vld;
  assign overflow    = ovf_q;
  assign overlap_err = ovl_q;
endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Scoreboard bench for hpdmc_rdcapture: expected words queued at capture edges, popped on handshake.
module tb_hpdmc_rdcapture;
  logic        sys_clk;
  logic        sys_rst_n;
  logic        rd_start;
  logic [2:0]  rd_delay;
  logic        word_swap;
  logic [15:0] iddr_q0;
  logic [15:0] iddr_q1;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        busy;
  logic        overflow;
  logic        overlap_err;
  logic        clear_err;

  hpdmc_rdcapture dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rd_start    (rd_start),
    .rd_delay    (rd_delay),
    .word_swap   (word_swap),
    .iddr_q0     (iddr_q0),
    .iddr_q1     (iddr_q1),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_last     (rd_last),
    .busy        (busy),
    .overflow    (overflow),
    .overlap_err (overlap_err),
    .clear_err   (clear_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [32:0] exp_q[$];
  logic [32:0] got, exp_w;
  logic [15:0] vc;
  int checks;
  int failures;

  // Advance one edge; the inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    vc = vc + 16'd1;
    iddr_q0 = 16'hA000 + vc;
    iddr_q1 = 16'hB000 + vc;
  endtask

  function automatic logic [31:0] cur_word();
    return word_swap ? {iddr_q1, iddr_q0} : {iddr_q0, iddr_q1};
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0; rd_start = 1'b0; rd_delay = 3'd0; word_swap = 1'b0;
    rd_ready = 1'b1; clear_err = 1'b0; vc = 16'd0;
    iddr_q0 = 16'hA000; iddr_q1 = 16'hB000;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({rd_valid, rd_last, busy, overflow, overlap_err} !== 5'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: vld=%b last=%b busy=%b ovf=%b ovl=%b data=%h, all zero required",
               rd_valid, rd_last, busy, overflow, overlap_err, rd_data);
    end
    sys_rst_n = 1'b1;
    tick();
    checks++;
    if ({rd_valid, rd_last, busy, overflow, overlap_err} !== 5'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_release: vld=%b busy=%b ovf=%b ovl=%b, all zero required",
               rd_valid, busy, overflow, overlap_err);
    end
  endtask

  task automatic test_basic();
    int first_vld = -1;
    rd_delay = 3'd2; word_swap = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_start = (i == 0);
      if (rd_valid === 1'b1 && first_vld < 0) first_vld = i;
      if (rd_valid && rd_ready) begin
        checks++;
        got = {rd_last, rd_data};
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL basic_word: got %h, no word expected", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin failures++; $display("FAIL basic_word: got %h required %h", got, exp_w); end
        end
      end
      if (i >= 3 && i <= 6) exp_q.push_back({i == 6, cur_word()});
      tick();
    end
    rd_start = 1'b0;
    checks++;
    if (first_vld != 4) begin failures++; $display("FAIL basic_latency: first valid at %0d, required 4", first_vld); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_count: %0d words missing, required 0", exp_q.size()); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: busy=%b required 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int first_pop = -1;
    int last_pop = -1;
    int npop = 0;
    rd_delay = 3'd0; rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_start = (i == 0) || (i == 4);
      if (rd_valid && rd_ready) begin
        checks++;
        npop++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        got = {rd_last, rd_data};
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_word: got %h, no word expected", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin failures++; $display("FAIL b2b_word: got %h required %h", got, exp_w); end
        end
      end
      if (i >= 1 && i <= 8) exp_q.push_back({(i == 4) || (i == 8), cur_word()});
      tick();
    end
    rd_start = 1'b0;
    checks++;
    if (npop != 8 || last_pop - first_pop != 7) begin
      failures++; $display("FAIL b2b_contig: %0d words over span %0d, required 8 over 7", npop, last_pop - first_pop);
    end
    checks++;
    if (overlap_err !== 1'b0) begin failures++; $display("FAIL b2b_overlap: overlap_err=%b required 0", overlap_err); end
    exp_q.delete();
  endtask

  task automatic test_overlap();
    rd_delay = 3'd0; rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_start = (i == 0) || (i == 2);
      clear_err = (i == 3);
      if (rd_valid && rd_ready) begin
        checks++;
        got = {rd_last, rd_data};
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL overlap_word: got %h, no word expected", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin failures++; $display("FAIL overlap_word: got %h required %h", got, exp_w); end
        end
      end
      if (i >= 1 && i <= 4) exp_q.push_back({i == 4, cur_word()});
      tick();
    end
    rd_start = 1'b0; clear_err = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL overlap_count: %0d words missing, required 0", exp_q.size()); end
    checks++;
    if (overlap_err !== 1'b1) begin failures++; $display("FAIL overlap_flag: overlap_err=%b required 1", overlap_err); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (overlap_err !== 1'b0) begin failures++; $display("FAIL overlap_clear: overlap_err=%b required 0", overlap_err); end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    rd_delay = 3'd0; rd_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rd_start = (i == 0) || (i == 4) || (i == 8);
      if (i >= 1 && i <= 8) exp_q.push_back({(i == 4) || (i == 8), cur_word()});
      tick();
    end
    rd_start = 1'b0;
    checks++;
    if (overflow !== 1'b1 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_flag: overflow=%b rd_valid=%b, required 1 and 1", overflow, rd_valid);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid && rd_ready) begin
        checks++;
        got = {rd_last, rd_data};
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL ovf_word: got %h, no word expected", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin failures++; $display("FAIL ovf_word: got %h required %h", got, exp_w); end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL ovf_drain: %0d missing busy=%b, required 0 and 0", exp_q.size(), busy);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: overflow=%b required 0", overflow); end
    exp_q.delete();
  endtask

  task automatic test_swap();
    rd_delay = 3'd1; rd_ready = 1'b1; word_swap = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iddr_q0 = 16'h1234; iddr_q1 = 16'h5678;
      rd_start = (i == 0);
      if (rd_valid && rd_ready) begin
        checks++;
        got = {rd_last, rd_data};
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL swap_word: got %h, no word expected", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin failures++; $display("FAIL swap_word: got %h required %h", got, exp_w); end
        end
      end
      if (i >= 2 && i <= 5) exp_q.push_back({i == 5, 32'h5678_1234});
      tick();
    end
    rd_start = 1'b0; word_swap = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL swap_count: %0d words missing, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_delay_sweep();
    rd_ready = 1'b1; word_swap = 1'b0;
    for (int d = 0; d < 8; d++) begin
      rd_delay = 3'(d);
      for (int i = 0; i < 20; i++) begin
        rd_start = (i == 0);
        if (rd_valid && rd_ready) begin
          checks++;
          got = {rd_last, rd_data};
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL sweep_word d=%0d: got %h, no word expected", d, got);
          end else begin
            exp_w = exp_q.pop_front();
            if (got !== exp_w) begin failures++; $display("FAIL sweep_word d=%0d: got %h required %h", d, got, exp_w); end
          end
        end
        if (i >= 1 + d && i <= 4 + d) exp_q.push_back({i == 4 + d, cur_word()});
        tick();
      end
      rd_start = 1'b0;
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
        failures++; $display("FAIL sweep_end d=%0d: %0d missing busy=%b, required 0 and 0", d, exp_q.size(), busy);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    rd_delay = 3'd0; rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, rd_last, busy, overflow, overlap_err} !== 5'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL midrst_outputs: vld=%b last=%b busy=%b data=%h, all zero required", rd_valid, rd_last, busy, rd_data);
    end
    tick();
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_word: rd_valid=%b at cycle %0d, required 0", rd_valid, i); end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: busy=%b required 0", busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overlap();
    test_overflow();
    test_swap();
    test_delay_sweep();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end
endmodule

// File: doc/hpdmc_rdcapture.md
Name: hpdmc_rdcapture

Overview:
Read-data capture stage directly downstream of the 16-bit DDR input register bank in the HPDMC SDRAM controller datapath.
- Each sys_clk cycle it merges the rising-edge and falling-edge 16-bit halves into one 32-bit word.
- It uses a programmable delay after each issued read command to select the valid words of a burst.
- Captured bursts are buffered in a small FIFO and presented to the bus interface through a valid/ready handshake, with a last-word marker.

Parameters:
BURST_LEN, 4, 32-bit words captured per read burst (2..8)
RD_DELAY_MAX, 7, largest supported read delay in cycles; sets delay-line length
FIFO_DEPTH, 8, words of output buffering (power of 2, >= BURST_LEN)

Ports:
sys_clk  in  1  system clock, same clock that drives the DDR input register bank
sys_rst_n  in  1  asynchronous active-low reset
rd_start  in  1  one-cycle pulse from the command scheduler when a READ is issued
rd_delay  in  3  cycles from rd_start to the first valid beat (0..RD_DELAY_MAX), static during operation
word_swap  in  1  0: word = {q0,q1}; 1: word = {q1,q0}
iddr_q0  in  16  rising-edge half from the DDR input registers
iddr_q1  in  16  falling-edge half from the DDR input registers
rd_data  out  32  captured word at FIFO head
rd_valid  out  1  rd_data/rd_last valid
rd_ready  in  1  consumer accepts the head word when rd_valid & rd_ready
rd_last  out  1  head word is the final word of its burst
busy  out  1  delay line non-zero, capture active, or FIFO non-empty
overflow  out  1  sticky: a captured word was dropped because the FIFO was full
overlap_err  out  1  sticky: a burst start fired while a capture was in progress
clear_err  in  1  synchronous clear of overflow and overlap_err

Behaviour:
- Reset: all outputs 0, FIFO empty, delay line cleared, capture counter idle. Reset asserted mid-burst discards all pending and buffered data.
- Delay line:
  - Shift register of RD_DELAY_MAX+1 bits; rd_start is shifted in at each edge.
  - A burst start ("tap") fires at edge t+1+rd_delay, where t is the edge at which rd_start was sampled high.
- Capture:
  - On a tap with the counter idle, the word formed from iddr_q0/q1 at that edge is captured and the counter is loaded with BURST_LEN-1.
  - Each following edge captures one word and decrements the counter; capture stops after BURST_LEN words total.
  - The last captured word of a burst is tagged last=1; the FIFO is 33 bits wide.
- Back-to-back bursts: a tap at the edge immediately after the final beat is legal and seamless.
- Overlap: a tap while the counter is active, including at the final-beat edge, is ignored. overlap_err is set and the current burst completes unchanged.
- FIFO:
  - Push happens at the capture edge. rd_valid rises in the cycle after that edge (registered first-word fall-through).
  - Pop happens when rd_valid & rd_ready.
  - Simultaneous push and pop while full is legal: no drop.
  - Push while full with no pop drops the word and sets overflow. A dropped last word loses its marker; no recovery is attempted.
- Sticky flags: clear_err clears both flags. If a set event and clear_err occur in the same cycle, the set wins.
- busy is combinational from the delay line, counter and FIFO state.
- Throughput: one word per cycle in and out; read-command-to-rd_valid latency is rd_delay+2 cycles.

Test Plan:
- rd_delay=2, word_swap=0, rd_start at edge 10, q0/q1 = 0xA000+n/0xB000+n from edge 13 onward, rd_ready=1 -> rd_data 0xA003B003, 0xA004B004, 0xA005B005, 0xA006B006 on consecutive cycles, rd_last only on the 4th, busy low afterwards.
- Two rd_start pulses 4 cycles apart, rd_delay=0 -> 8 contiguous words, rd_last on words 4 and 8, overlap_err=0; pulses 2 cycles apart -> 4 words only, overlap_err=1.
- rd_ready=0 during three bursts (12 words, FIFO_DEPTH=8) -> 8 words retained, overflow=1, then drained in order; clear_err -> overflow=0.
- word_swap=1 with q0=0x1234, q1=0x5678 -> rd_data=0x56781234.
- sys_rst_n pulsed low during 2nd beat of a burst -> outputs 0 immediately, no words emitted after release, busy=0.
- rd_delay sweep 0..7 -> the first captured word matches the input at edge t+1+rd_delay in every case.
